// File: rtl/stream_filter_cfg_master.sv
// Turns host command packets (one header word plus N payload words) into
// single-cycle configuration writes for stream_filter.
module stream_filter_cfg_master #(
  parameter int CFG_DWIDTH = 32,
  parameter int CFG_AWIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CFG_DWIDTH-1:0] cmd_data,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  output logic [CFG_DWIDTH-1:0] cfg_data,
  output logic [CFG_AWIDTH-1:0] cfg_addr,
  output logic                  cfg_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [1:0] {IDLE, PAYLOAD, DRAIN, DONE} state_t;

  state_t                state;
  logic [15:0]           count;
  logic [CFG_AWIDTH-1:0] addr;

  logic                  xfer;
  logic [15:0]           hdr_len;
  logic [CFG_AWIDTH-1:0] hdr_addr;
  logic                  hdr_addr_ok;
  logic                  last_word;

  assign xfer        = cmd_valid && cmd_ready;
  assign hdr_len     = cmd_data[31:16];
  assign hdr_addr    = cmd_data[CFG_AWIDTH-1:0];
  assign hdr_addr_ok = (hdr_addr >= CFG_AWIDTH'(1)) && (hdr_addr <= CFG_AWIDTH'(3));
  assign last_word   = (count == 16'd1);

  // NOTE: all state and outputs below are registers, so every assignment is
  // non-blocking; a blocking one would let later statements see the new value.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: every register, cfg_data included, is cleared so that nothing
      // stale from an abandoned packet is visible after reset.
      state     <= IDLE;
      count     <= '0;
      addr      <= '0;
      cfg_data  <= '0;
      cfg_addr  <= '0;
      cfg_valid <= 1'b0;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      cfg_valid <= 1'b0;
      done      <= 1'b0;
      cmd_ready <= 1'b1;
      case (state)
        IDLE: begin
          if (xfer) begin
            addr  <= hdr_addr;
            count <= hdr_len;
            if (hdr_len == 16'd0) begin
              err <= 1'b1;
            end else if (!hdr_addr_ok) begin
              err   <= 1'b1;
              state <= DRAIN;
              busy  <= 1'b1;
            end else begin
              state <= PAYLOAD;
              busy  <= 1'b1;
            end
          end
        end
        PAYLOAD: begin
          if (xfer) begin
            cfg_valid <= 1'b1;
            cfg_data  <= cmd_data;
            cfg_addr  <= addr;
            count     <= count - 16'd1;
            // The final write and the done pulse share the one-cycle DONE state.
            if (last_word) begin
              state     <= DONE;
              done      <= 1'b1;
              cmd_ready <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (xfer) begin
            count <= count - 16'd1;
            if (last_word) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stream_filter_cfg_master.sv
// Self-checking bench: directed packets plus random packets, compared against a
// packet-level reference model that predicts each cycle's outputs.
module tb_stream_filter_cfg_master;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cfg_data;
  logic [4:0]  cfg_addr;
  logic        cfg_valid;
  logic        busy;
  logic        done;
  logic        err;

  stream_filter_cfg_master #(.CFG_DWIDTH(32), .CFG_AWIDTH(5)) dut (
    .clk(clk), .rst(rst), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cfg_data(cfg_data), .cfg_addr(cfg_addr),
    .cfg_valid(cfg_valid), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: packet-level bookkeeping plus next-cycle expectations.
  int          m_rem;
  logic        m_ok;
  logic [4:0]  m_addr;
  logic        exp_err, exp_busy, exp_ready, exp_wr, exp_done;
  logic [31:0] exp_data;
  logic [4:0]  exp_addr;
  int          n_wr, n_done, cyc, stall_mode;

  task automatic model_reset();
    m_rem = 0; m_ok = 1'b0; m_addr = '0;
    exp_err = 1'b0; exp_busy = 1'b0; exp_ready = 1'b1;
    exp_wr = 1'b0; exp_done = 1'b0; exp_data = '0; exp_addr = '0;
  endtask

  task automatic model_accept(input logic [31:0] d);
    int n;
    if (m_rem == 0) begin
      n = int'(d[31:16]);
      if (n == 0) begin
        exp_err = 1'b1;
      end else begin
        m_rem    = n;
        m_addr   = d[4:0];
        m_ok     = (m_addr >= 5'd1) && (m_addr <= 5'd3);
        exp_busy = 1'b1;
        if (!m_ok) exp_err = 1'b1;
      end
    end else begin
      m_rem--;
      if (m_ok) begin
        exp_wr = 1'b1; exp_addr = m_addr; exp_data = d;
      end
      if (m_rem == 0) begin
        if (m_ok) begin
          exp_done = 1'b1; exp_ready = 1'b0;
        end else begin
          exp_busy = 1'b0;
        end
      end
    end
  endtask

  task automatic check_cycle();
    check("cmd_ready", cmd_ready, exp_ready);
    check("busy", busy, exp_busy);
    check("done", done, exp_done);
    check("err", err, exp_err);
    check("cfg_valid", cfg_valid, exp_wr);
    check("cfg_addr", cfg_addr, exp_addr);
    check("cfg_data", cfg_data, exp_data);
    if (cfg_valid) n_wr++;
    if (done) n_done++;
  endtask

  // One clock: check what the last edge produced, then drive the next inputs.
  task automatic tick(input logic v, input logic [31:0] d, output logic x);
    @(negedge clk);
    check_cycle();
    if (exp_done) exp_busy = 1'b0;
    exp_wr = 1'b0; exp_done = 1'b0; exp_ready = 1'b1;
    cmd_valid = v;
    cmd_data  = d;
    x = v && cmd_ready;
    cyc++;
    if (x) model_accept(d);
  endtask

  task automatic send_word(input logic [31:0] d);
    logic x;
    logic v;
    x = 1'b0;
    for (int tries = 0; tries < 64 && !x; tries++) begin
      case (stall_mode)
        1:       v = (cyc % 4) != 3;
        2:       v = $urandom_range(3) != 0;
        default: v = 1'b1;
      endcase
      tick(v, d, x);
    end
    if (!x) check("transfer_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int n);
    logic x;
    for (int i = 0; i < n; i++) tick(1'b0, $urandom, x);
  endtask

  task automatic do_reset(input int cycles, input bit pre_check);
    if (pre_check) begin
      @(negedge clk);
      check_cycle();
    end
    rst = 1'b1;
    cmd_valid = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check("rst_cmd_ready", cmd_ready, 1'b0);
      check("rst_cfg_valid", cfg_valid, 1'b0);
      check("rst_cfg_data", cfg_data, 32'd0);
      check("rst_cfg_addr", cfg_addr, 5'd0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_err", err, 1'b0);
    end
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w0, d0, n, a;
    cmd_valid = 1'b0; cmd_data = '0; rst = 1'b1;
    n_wr = 0; n_done = 0; cyc = 0; stall_mode = 0;
    model_reset();

    do_reset(6, 1'b0);

    // Single write to rescale register.
    w0 = n_wr; d0 = n_done;
    send_word(32'h0001_0003);
    send_word(32'h0000_0C1B);
    idle(2);
    check("single_writes", n_wr - w0, 1);
    check("single_done", n_done - d0, 1);

    // 30 kernel writes with valid dropped every 4th cycle.
    stall_mode = 1;
    w0 = n_wr; d0 = n_done;
    send_word(32'h001E_0002);
    for (int i = 0; i < 30; i++) send_word(32'h0000_0800);
    idle(2);
    check("stall_writes", n_wr - w0, 30);
    check("stall_done", n_done - d0, 1);
    stall_mode = 0;

    // Zero-length header, then a good packet still completes.
    w0 = n_wr; d0 = n_done;
    send_word(32'h0000_0001);
    idle(1);
    check("zero_len_err", err, 1'b1);
    send_word(32'h0001_0001);
    send_word(32'h0000_000A);
    idle(2);
    check("after_err_writes", n_wr - w0, 1);
    check("after_err_done", n_done - d0, 1);

    // Address 0 packet is drained without writes.
    w0 = n_wr; d0 = n_done;
    send_word(32'h0002_0000);
    send_word($urandom);
    send_word($urandom);
    idle(2);
    check("drain_writes", n_wr - w0, 0);
    check("drain_done", n_done - d0, 0);

    // Reset in the middle of a packet, then a fresh packet.
    send_word(32'h000A_0002);
    for (int i = 0; i < 5; i++) send_word($urandom);
    d0 = n_done;
    do_reset(3, 1'b1);
    idle(1);
    check("mid_reset_no_done", n_done - d0, 0);
    w0 = n_wr; d0 = n_done;
    send_word(32'h0001_0001);
    send_word(32'h1234_5678);
    idle(2);
    check("post_reset_writes", n_wr - w0, 1);
    check("post_reset_done", n_done - d0, 1);

    // Random packets, random stalls, occasional bad addresses and zero lengths.
    stall_mode = 2;
    for (int p = 0; p < 40; p++) begin
      n = $urandom_range(0, 6);
      a = ($urandom_range(3) == 0) ? $urandom_range(0, 31) : $urandom_range(1, 3);
      send_word({n[15:0], 11'($urandom), a[4:0]});
      for (int i = 0; i < n; i++) send_word($urandom);
      idle($urandom_range(0, 2));
    end
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
